// File: rtl/spell_wb_pkg.sv
// Shared widths and FSM state encoding for the SPELL Wishbone SRAM responder.
package spell_wb_pkg;

    localparam int WB_ADDR_W  = 10;
    localparam int WB_DATA_W  = 32;
    localparam int WB_SEL_W   = 4;
    localparam int WAIT_CNT_W = 4;
    localparam int WORD_IDX_W = WB_ADDR_W - 2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RESP,
        DONE,
        CLEAR
    } state_t;

endpackage

// File: rtl/spell_wb_sram_array.sv
// Word-organised storage with one synchronous port, per-byte write enables and a registered read.
module spell_wb_sram_array
    import spell_wb_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [WB_SEL_W-1:0]   wr_mask,
    input  logic [WORD_IDX_W-1:0] addr,
    input  logic [WB_DATA_W-1:0]  wr_data,
    input  logic                  rd_en,
    input  logic                  rd_clr,
    output logic [WB_DATA_W-1:0]  rd_data
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [WB_DATA_W-1:0] mem [DEPTH_WORDS];
    logic [IDX_W-1:0]     idx;
    logic                 unused_addr_hi;

    assign idx            = addr[IDX_W-1:0];
    assign unused_addr_hi = ^(addr >> IDX_W);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < WB_SEL_W; k++) begin
                if (wr_mask[k]) begin
                    mem[idx][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

    // rd_clr lets the caller return zero for indices that have no backing word
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_clr ? '0 : mem[idx];
        end
    end

endmodule

// File: rtl/spell_wb_sram.sv
// Wishbone classic responder standing in for the SPELL SRAM macro: wait states,
// optional post-reset zeroing sweep, cyc-drop abort and out-of-range handling.
module spell_wb_sram
    import spell_wb_pkg::*;
#(
    parameter int DEPTH_WORDS    = 256,
    parameter int WAIT_STATES    = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_we_i,
    input  logic [WB_SEL_W-1:0]  wb_sel_i,
    input  logic [WB_ADDR_W-1:0] wb_addr_i,
    input  logic [WB_DATA_W-1:0] wb_dat_i,
    output logic [WB_DATA_W-1:0] wb_dat_o,
    output logic                 wb_ack_o,
    output logic                 busy_o
);

    // state | meaning
    // IDLE  | waiting for cyc&stb; request captured here
    // WAIT  | counting wait states; cyc low aborts
    // RESP  | ack high for one cycle
    // DONE  | guard cycle so a held stb is not serviced twice
    // CLEAR | zeroing sweep after reset

    localparam logic [WORD_IDX_W-1:0] CLEAR_LAST = WORD_IDX_W'(DEPTH_WORDS - 1);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD  = WAIT_CNT_W'(WAIT_STATES);
    localparam logic [WORD_IDX_W:0]   DEPTH_LIM  = (WORD_IDX_W + 1)'(DEPTH_WORDS);

    state_t                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wait_q, wait_d;
    logic [WORD_IDX_W-1:0]   clear_idx_q, clear_idx_d;
    logic                    ack_q;
    logic                    commit;
    logic                    capture;

    logic                    req_we;
    logic [WB_SEL_W-1:0]     req_sel;
    logic [WORD_IDX_W-1:0]   req_idx;
    logic [WB_DATA_W-1:0]    req_dat;

    logic                    c_we;
    logic [WB_SEL_W-1:0]     c_sel;
    logic [WORD_IDX_W-1:0]   c_idx;
    logic [WB_DATA_W-1:0]    c_dat;
    logic                    in_range;

    logic                    mem_wr_en;
    logic [WB_SEL_W-1:0]     mem_wr_mask;
    logic [WORD_IDX_W-1:0]   mem_addr;
    logic [WB_DATA_W-1:0]    mem_wr_data;
    logic                    mem_rd_en;
    logic                    mem_rd_clr;
    logic                    unused_addr_lsb;

    assign unused_addr_lsb = ^wb_addr_i[1:0];

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        clear_idx_d = clear_idx_q;
        commit      = 1'b0;
        capture     = 1'b0;
        case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    capture = 1'b1;
                    wait_d  = WAIT_LOAD;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q - 1'b1;
                    if (wait_q == WAIT_CNT_W'(1)) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end
                end
            end
            RESP:  state_d = DONE;
            DONE:  state_d = IDLE;
            CLEAR: begin
                clear_idx_d = clear_idx_q + 1'b1;
                if (clear_idx_q == CLEAR_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // With zero wait states the commit happens on the capture edge, so use the live bus
    always_comb begin
        c_we     = (state_q == IDLE) ? wb_we_i               : req_we;
        c_sel    = (state_q == IDLE) ? wb_sel_i              : req_sel;
        c_idx    = (state_q == IDLE) ? wb_addr_i[WB_ADDR_W-1:2] : req_idx;
        c_dat    = (state_q == IDLE) ? wb_dat_i              : req_dat;
        in_range = {1'b0, c_idx} < DEPTH_LIM;
    end

    always_comb begin
        mem_addr    = c_idx;
        mem_wr_en   = 1'b0;
        mem_wr_mask = c_sel;
        mem_wr_data = c_dat;
        mem_rd_en   = 1'b0;
        mem_rd_clr  = !in_range;
        if (state_q == CLEAR) begin
            mem_addr    = clear_idx_q;
            mem_wr_en   = 1'b1;
            mem_wr_mask = '1;
            mem_wr_data = '0;
        end else if (commit) begin
            mem_wr_en = c_we && in_range;
            mem_rd_en = !c_we;
        end
        if (rst) begin
            mem_wr_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            wait_q      <= '0;
            clear_idx_q <= '0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            clear_idx_q <= clear_idx_d;
            ack_q       <= commit;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            req_we  <= wb_we_i;
            req_sel <= wb_sel_i;
            req_idx <= wb_addr_i[WB_ADDR_W-1:2];
            req_dat <= wb_dat_i;
        end
    end

    spell_wb_sram_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (mem_wr_en),
        .wr_mask(mem_wr_mask),
        .addr   (mem_addr),
        .wr_data(mem_wr_data),
        .rd_en  (mem_rd_en),
        .rd_clr (mem_rd_clr),
        .rd_data(wb_dat_o)
    );

    assign wb_ack_o = ack_q;
    assign busy_o   = (state_q == CLEAR);

endmodule

// File: tb/tb_spell_wb_sram.sv
// Bench for spell_wb_sram: three configurations checked every cycle against a transaction-level model.
module tb_spell_wb_sram;

    localparam int NDUT = 3;
    localparam int DEP [NDUT] = '{256, 64, 256};
    localparam int WS  [NDUT] = '{1, 0, 3};
    localparam int CLR [NDUT] = '{1, 1, 0};

    logic clk;
    logic        rst_s  [NDUT];
    logic        cyc_s  [NDUT];
    logic        stb_s  [NDUT];
    logic        we_s   [NDUT];
    logic [3:0]  sel_s  [NDUT];
    logic [9:0]  adr_s  [NDUT];
    logic [31:0] wdat_s [NDUT];
    logic [31:0] dat_o  [NDUT];
    logic        ack_o  [NDUT];
    logic        busy_o [NDUT];

    int n_checks;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    spell_wb_sram #(.DEPTH_WORDS(256), .WAIT_STATES(1), .CLEAR_ON_RESET(1)) u_dut0 (
        .clk(clk), .rst(rst_s[0]), .wb_cyc_i(cyc_s[0]), .wb_stb_i(stb_s[0]), .wb_we_i(we_s[0]),
        .wb_sel_i(sel_s[0]), .wb_addr_i(adr_s[0]), .wb_dat_i(wdat_s[0]),
        .wb_dat_o(dat_o[0]), .wb_ack_o(ack_o[0]), .busy_o(busy_o[0]));

    spell_wb_sram #(.DEPTH_WORDS(64), .WAIT_STATES(0), .CLEAR_ON_RESET(1)) u_dut1 (
        .clk(clk), .rst(rst_s[1]), .wb_cyc_i(cyc_s[1]), .wb_stb_i(stb_s[1]), .wb_we_i(we_s[1]),
        .wb_sel_i(sel_s[1]), .wb_addr_i(adr_s[1]), .wb_dat_i(wdat_s[1]),
        .wb_dat_o(dat_o[1]), .wb_ack_o(ack_o[1]), .busy_o(busy_o[1]));

    spell_wb_sram #(.DEPTH_WORDS(256), .WAIT_STATES(3), .CLEAR_ON_RESET(0)) u_dut2 (
        .clk(clk), .rst(rst_s[2]), .wb_cyc_i(cyc_s[2]), .wb_stb_i(stb_s[2]), .wb_we_i(we_s[2]),
        .wb_sel_i(sel_s[2]), .wb_addr_i(adr_s[2]), .wb_dat_i(wdat_s[2]),
        .wb_dat_o(dat_o[2]), .wb_ack_o(ack_o[2]), .busy_o(busy_o[2]));

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d t=%0t: got %h, expected %h", name, d, $time, act, exp);
        end
    endtask

    // Transaction-level reference: a request is taken once the responder is free,
    // commits WAIT_STATES edges later, acks right after, and frees up 3 edges after commit.
    int          edge_n;
    bit          pend      [NDUT];
    int          commit_at [NDUT];
    bit          p_we      [NDUT];
    logic [3:0]  p_sel     [NDUT];
    int          p_idx     [NDUT];
    logic [31:0] p_dat     [NDUT];
    int          busy_until[NDUT];
    int          free_at   [NDUT];
    bit          e_ack     [NDUT];
    bit          e_busy    [NDUT];
    bit          mvalid    [NDUT];
    logic [31:0] e_dat     [NDUT];
    logic [31:0] mm        [NDUT][256];

    initial begin
        edge_n = 0;
        for (int d = 0; d < NDUT; d++) begin
            pend[d] = 1'b0; mvalid[d] = 1'b0; free_at[d] = 0; busy_until[d] = 0;
            e_ack[d] = 1'b0; e_busy[d] = 1'b0; e_dat[d] = 32'h0;
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < NDUT; d++) begin
                e_ack[d] = 1'b0;
                if (rst_s[d]) begin
                    pend[d]   = 1'b0;
                    e_dat[d]  = 32'h0;
                    mvalid[d] = 1'b1;
                    if (CLR[d] != 0) begin
                        busy_until[d] = edge_n + DEP[d];
                        free_at[d]    = edge_n + DEP[d] + 1;
                        for (int i = 0; i < DEP[d]; i++) mm[d][i] = 32'h0;
                    end else begin
                        busy_until[d] = edge_n;
                        free_at[d]    = edge_n + 1;
                    end
                end else begin
                    if (!pend[d] && edge_n >= free_at[d] && cyc_s[d] && stb_s[d]) begin
                        pend[d]      = 1'b1;
                        commit_at[d] = edge_n + WS[d];
                        p_we[d]      = we_s[d];
                        p_sel[d]     = sel_s[d];
                        p_idx[d]     = int'(adr_s[d]) / 4;
                        p_dat[d]     = wdat_s[d];
                    end else if (pend[d] && !cyc_s[d]) begin
                        pend[d]    = 1'b0;
                        free_at[d] = edge_n + 1;
                    end
                    if (pend[d] && edge_n == commit_at[d]) begin
                        pend[d]    = 1'b0;
                        e_ack[d]   = 1'b1;
                        free_at[d] = edge_n + 3;
                        if (p_idx[d] < DEP[d]) begin
                            if (p_we[d]) begin
                                for (int k = 0; k < 4; k++)
                                    if (p_sel[d][k]) mm[d][p_idx[d]][8*k +: 8] = p_dat[d][8*k +: 8];
                            end else begin
                                e_dat[d] = mm[d][p_idx[d]];
                            end
                        end else if (!p_we[d]) begin
                            e_dat[d] = 32'h0;
                        end
                    end
                end
                e_busy[d] = (edge_n < busy_until[d]);
            end
            edge_n++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                if (mvalid[d]) begin
                    chk("ack", d, 32'(ack_o[d]), 32'(e_ack[d]));
                    chk("busy", d, 32'(busy_o[d]), 32'(e_busy[d]));
                    chk("dat_o", d, dat_o[d], e_dat[d]);
                end
            end
        end
    end

    task automatic xfer(input int d, input bit we, input logic [9:0] a, input logic [3:0] sel,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd);
        cyc_s[d] = 1'b1; stb_s[d] = 1'b1; we_s[d] = we;
        sel_s[d] = sel; adr_s[d] = a; wdat_s[d] = wd;
        lat = -1;
        for (int k = 1; k <= 400 && lat < 0; k++) begin
            @(negedge clk);
            if (ack_o[d] === 1'b1) lat = k;
        end
        rd = dat_o[d];
        cyc_s[d] = 1'b0; stb_s[d] = 1'b0; we_s[d] = 1'b0;
        if (lat < 0) chk("ack_timeout", d, 32'hFFFF_FFFF, 32'h0);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int          lat;
        int          bcnt;
        int          acks;
        logic [31:0] rd;
        logic [15:0] hist;
        n_checks = 0;
        n_err    = 0;
        for (int d = 0; d < NDUT; d++) begin
            rst_s[d] = 1'b1; cyc_s[d] = 1'b0; stb_s[d] = 1'b0; we_s[d] = 1'b0;
            sel_s[d] = 4'h0; adr_s[d] = 10'h0; wdat_s[d] = 32'h0;
        end
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) rst_s[d] = 1'b0;
        for (int k = 0; k < 400 && (busy_o[0] || busy_o[1]); k++) @(negedge clk);
        chk("initial_sweep_done", 0, 32'(busy_o[0] | busy_o[1]), 32'h0);

        // full-word write/read, one wait state
        xfer(0, 1'b1, 10'h010, 4'hF, 32'hDEADBEEF, lat, rd);
        chk("wr_latency_w1", 0, 32'(lat), 32'd2);
        xfer(0, 1'b0, 10'h012, 4'h0, 32'h0, lat, rd);
        chk("rd_latency_w1", 0, 32'(lat), 32'd2);
        chk("rd_full_word", 0, rd, 32'hDEADBEEF);

        // byte lanes; read ignores sel
        xfer(0, 1'b1, 10'h020, 4'hF, 32'h11223344, lat, rd);
        xfer(0, 1'b1, 10'h020, 4'b0100, 32'hAAAAAAAA, lat, rd);
        xfer(0, 1'b0, 10'h020, 4'b0001, 32'h0, lat, rd);
        chk("byte_lane_merge", 0, rd, 32'h11AA3344);

        xfer(0, 1'b1, 10'h3FC, 4'hF, 32'h12345678, lat, rd);
        xfer(0, 1'b0, 10'h3FC, 4'hF, 32'h0, lat, rd);
        chk("top_word_rd", 0, rd, 32'h12345678);

        // clear sweep with a read held throughout
        rst_s[0] = 1'b1;
        @(negedge clk);
        rst_s[0] = 1'b0;
        cyc_s[0] = 1'b1; stb_s[0] = 1'b1; we_s[0] = 1'b0; adr_s[0] = 10'h3FC; sel_s[0] = 4'hF;
        bcnt = busy_o[0] ? 1 : 0;
        lat  = -1;
        for (int k = 1; k <= 400 && lat < 0; k++) begin
            @(negedge clk);
            if (busy_o[0] === 1'b1) bcnt++;
            if (ack_o[0] === 1'b1) lat = k;
        end
        rd = dat_o[0];
        cyc_s[0] = 1'b0; stb_s[0] = 1'b0;
        chk("sweep_busy_cycles", 0, 32'(bcnt), 32'd256);
        chk("sweep_stalled_ack", 0, 32'(lat), 32'd258);
        chk("sweep_top_word", 0, rd, 32'h0);
        @(negedge clk);
        @(negedge clk);
        xfer(0, 1'b0, 10'h010, 4'hF, 32'h0, lat, rd);
        chk("sweep_word4", 0, rd, 32'h0);

        // held strobe, zero wait states
        cyc_s[1] = 1'b1; stb_s[1] = 1'b1; we_s[1] = 1'b1;
        sel_s[1] = 4'hF; adr_s[1] = 10'h008; wdat_s[1] = 32'h0BADC0DE;
        hist = 16'h0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            hist[k] = ack_o[1];
            if (k == 10) begin
                cyc_s[1] = 1'b0; stb_s[1] = 1'b0; we_s[1] = 1'b0;
            end
        end
        chk("held_stb_ack_pattern", 1, 32'(hist), 32'h0492);
        xfer(1, 1'b0, 10'h008, 4'hF, 32'h0, lat, rd);
        chk("rd_latency_w0", 1, 32'(lat), 32'd1);
        chk("held_stb_data", 1, rd, 32'h0BADC0DE);

        // out-of-range on a 64-word array
        xfer(1, 1'b1, 10'h000, 4'hF, 32'hCAFEF00D, lat, rd);
        xfer(1, 1'b1, 10'h0FC, 4'hF, 32'h600DF00D, lat, rd);
        xfer(1, 1'b1, 10'h100, 4'hF, 32'hFFFFFFFF, lat, rd);
        chk("oor_wr_ack", 1, 32'(lat), 32'd1);
        xfer(1, 1'b1, 10'h3FC, 4'hF, 32'hFFFFFFFF, lat, rd);
        xfer(1, 1'b0, 10'h100, 4'hF, 32'h0, lat, rd);
        chk("oor_rd_zero", 1, rd, 32'h0);
        xfer(1, 1'b0, 10'h000, 4'hF, 32'h0, lat, rd);
        chk("word0_untouched", 1, rd, 32'hCAFEF00D);
        xfer(1, 1'b0, 10'h0FC, 4'hF, 32'h0, lat, rd);
        chk("last_word_untouched", 1, rd, 32'h600DF00D);

        // abort by cyc drop, three wait states, no clear sweep
        xfer(2, 1'b1, 10'h014, 4'hF, 32'h0, lat, rd);
        chk("wr_latency_w3", 2, 32'(lat), 32'd4);
        cyc_s[2] = 1'b1; stb_s[2] = 1'b1; we_s[2] = 1'b1;
        sel_s[2] = 4'hF; adr_s[2] = 10'h014; wdat_s[2] = 32'h55;
        @(negedge clk);
        @(negedge clk);
        cyc_s[2] = 1'b0; stb_s[2] = 1'b0; we_s[2] = 1'b0;
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ack_o[2] === 1'b1) acks++;
        end
        chk("abort_no_ack", 2, 32'(acks), 32'd0);
        xfer(2, 1'b0, 10'h014, 4'hF, 32'h0, lat, rd);
        chk("rd_latency_w3", 2, 32'(lat), 32'd4);
        chk("abort_no_write", 2, rd, 32'h0);

        // reset in the middle of the wait states
        cyc_s[2] = 1'b1; stb_s[2] = 1'b1; we_s[2] = 1'b1;
        sel_s[2] = 4'hF; adr_s[2] = 10'h014; wdat_s[2] = 32'h55;
        @(negedge clk);
        @(negedge clk);
        rst_s[2] = 1'b1;
        @(negedge clk);
        rst_s[2] = 1'b0;
        cyc_s[2] = 1'b0; stb_s[2] = 1'b0; we_s[2] = 1'b0;
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ack_o[2] === 1'b1) acks++;
        end
        chk("rst_abort_no_ack", 2, 32'(acks), 32'd0);
        chk("no_sweep_busy", 2, 32'(busy_o[2]), 32'd0);
        xfer(2, 1'b0, 10'h014, 4'hF, 32'h0, lat, rd);
        chk("rst_abort_no_write", 2, rd, 32'h0);
        xfer(2, 1'b1, 10'h014, 4'b0001, 32'h55, lat, rd);
        xfer(2, 1'b0, 10'h014, 4'hF, 32'h0, lat, rd);
        chk("normal_write_after_abort", 2, rd, 32'h00000055);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spell_wb_sram.md
Name: spell_wb_sram

Overview:
Wishbone classic responder that sits on the far end of the SPELL core's SRAM bus and answers its code/data fetches and stores. It holds a word-organised, byte-lane-writable memory with configurable wait states, so SPELL can run against a synthesizable stand-in for the OpenRAM macro. It also provides an optional post-reset clear sweep, and it handles aborted cycles and out-of-range addresses deterministically.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; legal range 1..256.
WAIT_STATES, 1, extra cycles between request capture and ack; legal range 0..15.
CLEAR_ON_RESET, 1, when 1, reset starts a sweep that zeroes every word.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, synchronous, active-high.
wb_cyc_i  input  1  bus cycle valid.
wb_stb_i  input  1  strobe; a request is only seen when cyc and stb are both high.
wb_we_i  input  1  1 = write, 0 = read.
wb_sel_i  input  4  byte-lane enables; bit k covers dat[8k+7:8k].
wb_addr_i  input  10  byte address; word index = wb_addr_i[9:2]; bits [1:0] are ignored.
wb_dat_i  input  32  write data.
wb_dat_o  output  32  read data, registered.
wb_ack_o  output  1  transfer acknowledge, registered, one-cycle pulse.
busy_o  output  1  high while the clear sweep runs.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to CLEAR if CLEAR_ON_RESET=1, else IDLE.
  - wb_ack_o=0, wb_dat_o=32'h0, wait counter=0, clear index=0.
  - busy_o follows the state on the next cycle.
  - Reset mid-transaction drops that transaction: no ack, and no write if the commit edge has not yet occurred.
  - Array contents are not reset except through the sweep.
- CLEAR: each cycle writes 32'h0 to word[clear_idx] and increments clear_idx. After DEPTH_WORDS cycles the block goes to IDLE. busy_o=1 throughout. Bus requests are ignored with no ack; the master stalls.
- IDLE: if cyc&stb, latch we, sel, word index and dat_i, load the wait counter with WAIT_STATES, then go to WAIT, or to RESP when WAIT_STATES=0.
- WAIT: decrement the counter each cycle. At 0, go to RESP. If cyc drops at any edge in WAIT, abort to IDLE: no write, no ack.
- Commit edge (WAIT->RESP or IDLE->RESP):
  - Write: update only the lanes whose sel bit is set.
  - Read: load wb_dat_o with the full word regardless of sel.
  - wb_ack_o=1 in the following cycle, which is the RESP cycle.
- RESP: ack high for exactly one cycle, then go unconditionally to DONE.
- DONE: ack=0, one idle cycle, then IDLE. This guarantees a master that holds stb after ack (as SPELL does until its select drops) is not double-serviced within that cycle. A request still asserted in IDLE afterwards is a new transaction.
- Latency: request visible in cycle 0 → ack in cycle 1+WAIT_STATES. Minimum request-to-request spacing is 3+WAIT_STATES cycles.
- wb_dat_o holds its value between reads; writes do not change it.
- Out-of-range word index (>= DEPTH_WORDS): normal ack timing, write dropped, read returns 32'h0.
- If cyc drops during RESP, ack still completes and the write is already committed.
- Inputs are sampled only in IDLE; changes in WAIT, RESP or DONE are ignored apart from the cyc abort check.

Decomposition:
- Package spell_wb_pkg:
  - state enum {IDLE, WAIT, RESP, DONE, CLEAR}.
  - WB_ADDR_W=10, WB_DATA_W=32, WB_SEL_W=4.
  - Wait-counter width localparam = 4.
- Sub-module spell_wb_sram_array: DEPTH_WORDS x 32 storage, one synchronous read/write port with per-byte write enable. Used by both the FSM commit and the clear sweep.
- The top level holds the FSM, request latch, counters and range check.

Test Plan:
- Clear sweep: CLEAR_ON_RESET=1, DEPTH_WORDS=256, pulse rst → busy_o high for exactly 256 cycles. A request issued during that time gets no ack until after busy falls. A later read of addr 10'h3FC returns 32'h0.
- Full-word write/read: WAIT_STATES=1, write sel=4'hF, addr 10'h010, dat 32'hDEADBEEF → ack in cycle 2 after request. Read of addr 10'h012 → ack in cycle 2, wb_dat_o=32'hDEADBEEF.
- Byte lanes: word 10'h020 preset to 32'h11223344, write sel=4'b0100, dat 32'hAAAAAAAA → read returns 32'h11AA3344.
- Held strobe: master keeps cyc/stb high with the same write for 10 cycles, WAIT_STATES=0 → ack pulses in cycles 1, 4, 7, 10, each exactly one cycle wide, never back-to-back.
- Abort: WAIT_STATES=3, write 32'h55 to word 5 (previously 0) and drop cyc in cycle 2 → no ack, word 5 still reads 32'h0. Same case with rst asserted in cycle 2 → no ack and no write.
- Out of range: DEPTH_WORDS=64, write to addr 10'h100 → ack issued. Read back → 32'h0. Word 0 is unchanged.
